// File: rtl/video_system_keycode_event_queue.sv
// Keycode change-event FIFO: synchronises the keyboard keycode, queues {old, new} pairs on every
// change and lets software drain them over an Avalon-MM slave with an optional interrupt.
module video_system_keycode_event_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  in_port,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic [AW:0] FullCount = DEPTH[AW:0];

    logic [7:0]    key_sync;
    logic [7:0]    key_s;
    logic [7:0]    key_p;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic          irq_en;
    logic          capture_en;

    logic          empty;
    logic          full;
    logic          rd_en;
    logic          wr_en;
    logic          pop;
    logic          flush;
    logic          push_req;
    logic          drop;
    logic          push;
    logic          ovf_clr;
    logic [31:0]   status;
    logic [31:0]   rd_mux;
    logic [AW:0]   count_next;

    always_comb begin
        empty    = (count == '0);
        full     = (count == FullCount);
        rd_en    = chipselect & read;
        wr_en    = chipselect & write;
        pop      = rd_en & (address == 2'd0) & ~empty;
        flush    = wr_en & (address == 2'd2) & writedata[1];
        push_req = (key_s != key_p) & capture_en;
        // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
        drop     = push_req & full & ~pop;
        push     = push_req & ~drop & ~flush;
        ovf_clr  = wr_en & (address == 2'd1) & writedata[18];

        status         = '0;
        status[AW:0]   = count;
        status[16]     = empty;
        status[17]     = full;
        status[18]     = overflow;

        unique case (address)
            2'd0:    rd_mux = empty ? 32'd0 : {1'b1, 15'd0, mem[rd_ptr]};
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = {29'd0, capture_en, 1'b0, irq_en};
            default: rd_mux = {24'd0, key_s};
        endcase

        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_sync <= '0;
            key_s    <= '0;
            key_p    <= '0;
        end else begin
            key_sync <= in_port;
            key_s    <= key_sync;
            key_p    <= key_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {key_p, key_s};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            irq_en     <= 1'b0;
            capture_en <= 1'b1;
        end else begin
            // A new drop outranks a simultaneous W1C clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (wr_en && (address == 2'd2)) begin
                irq_en     <= writedata[0];
                capture_en <= writedata[2];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (rd_en) begin
                readdata <= rd_mux;
            end
            irq <= irq_en & (~empty | overflow);
        end
    end

endmodule

// File: tb/tb_video_system_keycode_event_queue.sv
// Randomised and directed bench for the keycode event queue, checked against a queue-based model.
module tb_video_system_keycode_event_queue;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_port = '0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic        m_ovf;
    logic        m_irq_en;
    logic        m_cap;
    logic [7:0]  m_sync;
    logic [7:0]  m_keys;
    logic [7:0]  m_keyp;
    logic [31:0] m_rdata;
    logic        m_irq;

    video_system_keycode_event_queue #(.DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        m_irq_en = 1'b0;
        m_cap    = 1'b1;
        m_sync   = '0;
        m_keys   = '0;
        m_keyp   = '0;
        m_rdata  = '0;
        m_irq    = 1'b0;
    endtask

    // Advance one clock: predict from pre-edge inputs/state, then compare after the edge.
    task automatic step();
        logic [31:0] nrd;
        logic        nirq;
        bit          rd, wr, pop, fl, preq, drop;
        int          sz;
        sz   = mq.size();
        rd   = chipselect && read;
        wr   = chipselect && write;
        nirq = m_irq_en && (sz != 0 || m_ovf);
        nrd  = m_rdata;
        if (rd) begin
            case (address)
                2'd0: nrd = (sz != 0) ? {1'b1, 15'd0, mq[0]} : 32'd0;
                2'd1: nrd = {13'd0, m_ovf, 1'(sz == DEPTH), 1'(sz == 0), 16'(sz)};
                2'd2: nrd = {29'd0, m_cap, 1'b0, m_irq_en};
                default: nrd = {24'd0, m_keys};
            endcase
        end
        pop  = rd && address == 2'd0 && sz > 0;
        fl   = wr && address == 2'd2 && writedata[1];
        preq = (m_keys != m_keyp) && m_cap;
        drop = preq && sz == DEPTH && !pop;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (preq && !drop) mq.push_back({m_keyp, m_keys});
        end
        if (wr && address == 2'd1 && writedata[18]) m_ovf = 1'b0;
        if (drop) m_ovf = 1'b1;
        if (wr && address == 2'd2) begin
            m_irq_en = writedata[0];
            m_cap    = writedata[2];
        end
        m_keyp  = m_keys;
        m_keys  = m_sync;
        m_sync  = in_port;
        m_rdata = nrd;
        m_irq   = nirq;
        @(posedge clk);
        #1;
        checks++;
        if (readdata !== m_rdata) begin
            errors++;
            $display("FAIL readdata t=%0t got %h expected %h", $time, readdata, m_rdata);
        end
        checks++;
        if (irq !== m_irq) begin
            errors++;
            $display("FAIL irq t=%0t got %b expected %b", $time, irq, m_irq);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_read(input logic [1:0] a);
        chipselect = 1'b1; read = 1'b1; address = a;
        step();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        step();
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got rd=%h irq=%b expected 0/0", readdata, irq);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        in_port = 8'h00;
        do_reset();
        idle(2);
        do_read(2'd1);
        checks++;
        if (readdata !== 32'h0001_0000) begin
            errors++;
            $display("FAIL reset_status got %h expected 00010000", readdata);
        end
        do_read(2'd3);
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_key got %h/%b expected 0/0", readdata, irq);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_seq [6];
        logic [1:0]  adr_seq [6];
        exp_seq = '{32'h2, 32'h8000_001C, 32'h1, 32'h8000_1C00, 32'h0, 32'h0001_0000};
        adr_seq = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
        in_port = 8'h1C;
        idle(4);
        in_port = 8'h00;
        idle(4);
        for (int i = 0; i < 6; i++) begin
            do_read(adr_seq[i]);
            checks++;
            if (readdata !== exp_seq[i]) begin
                errors++;
                $display("FAIL basic_%0d got %h expected %h", i, readdata, exp_seq[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_write(2'd2, 32'h5);
        for (int i = 1; i <= 17; i++) begin
            in_port = 8'(i);
            step();
        end
        idle(4);
        do_read(2'd1);
        checks++;
        if (readdata !== 32'h0006_0010 || irq !== 1'b1) begin
            errors++;
            $display("FAIL overflow_status got %h irq=%b expected 00060010 irq=1", readdata, irq);
        end
        repeat (16) do_read(2'd0);
        do_write(2'd1, 32'h0004_0000);
        idle(3);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL overflow_irq_drop got %b expected 0", irq);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 16; i++) begin
            in_port = 8'h20 + 8'(i);
            step();
        end
        idle(4);
        in_port = 8'h55;
        idle(2);
        do_read(2'd0);
        idle(2);
        do_read(2'd1);
        checks++;
        if (readdata !== 32'h0002_0010) begin
            errors++;
            $display("FAIL full_pop_status got %h expected 00020010", readdata);
        end
        repeat (15) do_read(2'd0);
        do_read(2'd0);
        checks++;
        if (readdata !== 32'h8000_2F55) begin
            errors++;
            $display("FAIL full_pop_last got %h expected 80002F55", readdata);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            in_port = 8'h40 + 8'(i);
            step();
        end
        in_port = 8'h60;
        idle(2);
        do_write(2'd2, 32'h2);
        idle(3);
        do_read(2'd1);
        checks++;
        if (readdata !== 32'h0001_0000) begin
            errors++;
            $display("FAIL flush_status got %h expected 00010000", readdata);
        end
        do_read(2'd2);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL flush_control got %h expected 00000000", readdata);
        end
    endtask

    task automatic test_capture();
        for (int i = 0; i < 8; i++) begin
            in_port = (i % 2 == 0) ? 8'h1D : 8'h00;
            idle(3);
            do_read(2'd3);
        end
        in_port = 8'h1D;
        idle(3);
        do_read(2'd1);
        checks++;
        if (readdata !== 32'h0001_0000) begin
            errors++;
            $display("FAIL capture_off_status got %h expected 00010000", readdata);
        end
        do_write(2'd2, 32'h4);
        in_port = 8'h23;
        idle(4);
        do_read(2'd0);
        checks++;
        if (readdata !== 32'h8000_1D23) begin
            errors++;
            $display("FAIL capture_on_entry got %h expected 80001D23", readdata);
        end
    endtask

    task automatic test_random();
        logic [7:0] keys [4];
        keys = '{8'h00, 8'h1C, 8'h23, 8'h1D};
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 1) == 0) in_port = keys[$urandom_range(0, 3)];
                chipselect = ($urandom_range(0, 2) == 0);
                read       = ($urandom_range(0, 1) == 0);
                write      = ($urandom_range(0, 3) == 0);
                address    = 2'($urandom_range(0, 3));
                writedata  = $urandom;
                if ($urandom_range(0, 7) != 0) writedata[1] = 1'b0;
                if ($urandom_range(0, 7) != 0) writedata[2] = 1'b1;
                step();
                chipselect = 1'b0; read = 1'b0; write = 1'b0;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_flush();
        test_capture();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
